// File: rtl/m_sram_req_sched.sv
// m_sram_req_sched: arbitrates camera-write and display-read bursts onto the shared SRAM controller.
// Define SRAM_SCHED_TIMEOUT_EN to bound busy states by TIMEOUT cycles and raise a sticky timeout_err.
module m_sram_req_sched #(
    parameter int                ADDR_W      = 24,
    parameter int                LVL_W       = 10,
    parameter int                BURST_LEN   = 16,
    parameter logic [ADDR_W-1:0] FRAME_WORDS = 24'd307200,
    parameter logic [LVL_W-1:0]  WR_URGENT   = 10'd768,
    parameter int                TIMEOUT     = 1023
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_free,
    input  logic              rd_enable,
    input  logic              ctrl_fifo_rd_en,
    input  logic              ctrl_fifo_wr_en,
    output logic              wr_req,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] sram_raddr,
    output logic              busy,
    output logic              wr_frame_done,
    output logic              rd_frame_done,
    output logic              timeout_err
);
    localparam int                CNT_W  = $clog2(BURST_LEN) + 1;
    localparam logic [LVL_W-1:0]  BL_LVL = LVL_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BL_ADR = ADDR_W'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_BUSY, RD_ISSUE, RD_BUSY, GAP} state_t;

    state_t            state;
    logic              last_rd;
    logic [CNT_W-1:0]  cnt;
    logic              wr_ok, rd_ok, pick_wr, pick_rd, beat, done;
    logic [ADDR_W-1:0] addr_cur, addr_nxt;

    always_comb begin
        wr_ok    = wr_fifo_level >= BL_LVL;
        rd_ok    = rd_enable && rd_fifo_free >= BL_LVL;
        // urgent level, sole eligibility, or round-robin turn all resolve to write
        pick_wr  = wr_ok && (wr_fifo_level >= WR_URGENT || !rd_ok || last_rd);
        pick_rd  = rd_ok && !pick_wr;
        beat     = state == WR_BUSY ? ctrl_fifo_rd_en : state == RD_BUSY ? ctrl_fifo_wr_en : 1'b0;
        done     = beat && cnt + 1'b1 == CNT_W'(BURST_LEN);
        addr_cur = state == WR_BUSY ? sram_waddr : sram_raddr;
        addr_nxt = addr_cur + BL_ADR == FRAME_WORDS ? '0 : addr_cur + BL_ADR;
    end

`ifdef SRAM_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt;
    logic            tmo;
    assign tmo = (state == WR_BUSY || state == RD_BUSY) && tcnt == TO_W'(TIMEOUT - 1);
`else
    // TIMEOUT is never negative, so the flag is constant 0 in this build
    assign timeout_err = TIMEOUT < 0;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_rd       <= 1'b1;
            cnt           <= '0;
            wr_req        <= 1'b0;
            rd_req        <= 1'b0;
            busy          <= 1'b0;
            sram_waddr    <= '0;
            sram_raddr    <= '0;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
`ifdef SRAM_SCHED_TIMEOUT_EN
            tcnt          <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            wr_req        <= 1'b0;
            rd_req        <= 1'b0;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
            cnt           <= cnt + CNT_W'(beat);
`ifdef SRAM_SCHED_TIMEOUT_EN
            tcnt          <= (state == WR_BUSY || state == RD_BUSY) ? tcnt + 1'b1 : '0;
`endif
            case (state)
                IDLE: begin
                    if (pick_wr || pick_rd) begin
                        state   <= pick_wr ? WR_ISSUE : RD_ISSUE;
                        wr_req  <= pick_wr;
                        rd_req  <= pick_rd;
                        last_rd <= pick_rd;
                        busy    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                WR_ISSUE: state <= WR_BUSY;
                RD_ISSUE: state <= RD_BUSY;
                WR_BUSY, RD_BUSY: begin
                    if (done) begin
                        state <= GAP;
                        if (state == WR_BUSY) sram_waddr <= addr_nxt;
                        else sram_raddr <= addr_nxt;
                        wr_frame_done <= state == WR_BUSY && addr_nxt == '0;
                        rd_frame_done <= state == RD_BUSY && addr_nxt == '0;
                    end
`ifdef SRAM_SCHED_TIMEOUT_EN
                    else if (tmo) begin
                        state       <= GAP;
                        timeout_err <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
